// File: rtl/tb_uart_if.sv
// Serial-monitor bus: line input plus decoded byte/strobe outputs of tb_uart.
// TB_UART_PARITY_EN adds the parity_err strobe.
interface tb_uart_if;
    logic        ser_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        rx_busy;
    logic [15:0] rx_count;
`ifdef TB_UART_PARITY_EN
    logic        parity_err;

    modport master (output ser_rx,
                    input  rx_data, rx_valid, frame_err, rx_busy, rx_count, parity_err);
    modport slave  (input  ser_rx,
                    output rx_data, rx_valid, frame_err, rx_busy, rx_count, parity_err);
`else
    modport master (output ser_rx,
                    input  rx_data, rx_valid, frame_err, rx_busy, rx_count);
    modport slave  (input  ser_rx,
                    output rx_data, rx_valid, frame_err, rx_busy, rx_count);
`endif
endinterface

// File: rtl/tb_uart.sv
// 8N1 UART receiver/monitor for the SoC serial TX pin: glitch rejection, framing
// errors, byte counter. Define TB_UART_PARITY_EN for 8E1 frames with parity_err.
module tb_uart #(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic      clock,
    input  logic      resetb,
    tb_uart_if.slave  rx_if
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic        sync_q, rxs_q;
    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] rx_count_q, rx_count_d;
`ifdef TB_UART_PARITY_EN
    logic        par_q, par_d;
    logic        parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        rx_count_d  = rx_count_q;
`ifdef TB_UART_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef TB_UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef TB_UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rxs_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
`ifdef TB_UART_PARITY_EN
                        // A good stop bit with even-parity mismatch drops the byte.
                        if ((^shift_q) != par_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = shift_q;
                            rx_count_d = rx_count_q + 16'd1;
                        end
`else
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                        rx_count_d = rx_count_q + 16'd1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            sync_q      <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_count_q  <= '0;
`ifdef TB_UART_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= rx_if.ser_rx;
            rxs_q       <= sync_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_count_q  <= rx_count_d;
`ifdef TB_UART_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.rx_busy   = (state_q != S_IDLE);
    assign rx_if.rx_count  = rx_count_q;
`ifdef TB_UART_PARITY_EN
    assign rx_if.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_tb_uart.sv
// Directed bench for tb_uart at CLKS_PER_BIT=16: vector table of single frames
// plus hand sequences for reset, latency, stream, glitch, break, wrap and parity.
module tb_tb_uart;
    localparam int unsigned CPB = 16;

    logic clock = 1'b0;
    logic resetb;
    tb_uart_if bus ();

    tb_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clock  (clock),
        .resetb (resetb),
        .rx_if  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_ferr = 0, n_both = 0, n_perr = 0;
    time t_valid = 0;
    logic [7:0] got_q[$];

    always @(negedge clock) begin
        if (bus.rx_valid) begin
            n_valid++;
            got_q.push_back(bus.rx_data);
            t_valid = $time;
        end
        if (bus.frame_err) n_ferr++;
        if (bus.rx_valid && bus.frame_err) n_both++;
`ifdef TB_UART_PARITY_EN
        if (bus.parity_err) n_perr++;
        if (bus.parity_err && (bus.rx_valid || bus.frame_err)) n_both++;
`endif
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];
    logic [7:0]  exp_data;
    logic [15:0] exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.ser_rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) send_bit(d[i]);
`ifdef TB_UART_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
    endtask

    task automatic idle(input int unsigned n);
        bus.ser_rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int unsigned k = 0;
        while (bus.rx_busy && k < 60 * CPB) begin
            @(negedge clock);
            k++;
        end
        check(name, 32'(bus.rx_busy), 32'd0);
    endtask

    initial begin
        int v0, f0, p0;
        int unsigned k;
        logic [31:0] act;
        logic seen_busy;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h55, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h3C, 1'b0, 0, 1};
        vecs[5] = '{8'h81, 1'b1, 1, 0};
        vecs[6] = '{8'h6E, 1'b0, 0, 1};

        resetb     = 1'b0;
        bus.ser_rx = 1'b1;
        exp_data   = 8'h00;
        exp_count  = 16'h0000;
        @(negedge clock);

        // Reset held with the line toggling
        for (int i = 0; i < 3; i++) begin
            bus.ser_rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clock);
        end
        check("rst_data",  32'(bus.rx_data),   32'h0);
        check("rst_valid", 32'(bus.rx_valid),  32'h0);
        check("rst_ferr",  32'(bus.frame_err), 32'h0);
        check("rst_busy",  32'(bus.rx_busy),   32'h0);
        check("rst_count", 32'(bus.rx_count),  32'h0);
        bus.ser_rx = 1'b1;
        resetb = 1'b1;
        idle(4);

        // Reset mid-frame discards the partial byte
        v0 = n_valid; f0 = n_ferr;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        resetb = 1'b0;
        @(negedge clock);
        check("midrst_busy", 32'(bus.rx_busy), 32'h0);
        bus.ser_rx = 1'b1;
        resetb = 1'b1;
        idle(12 * CPB);
        check("midrst_strobes", 32'(n_valid - v0 + n_ferr - f0), 32'h0);
        check("midrst_count",   32'(bus.rx_count), 32'h0);

        // Latency from the falling start edge to rx_valid
        v0 = n_valid;
        begin
            time t0;
            t0 = $time;
            send_frame(8'hC3, 1'b1);
            idle(2 * CPB);
            exp_data = 8'hC3; exp_count++;
            check("lat_valid", 32'(n_valid - v0), 32'd1);
            act = 32'((t_valid - t0) / 10);
`ifdef TB_UART_PARITY_EN
            check("lat_cycles_ok", 32'(act >= 32'(3 + CPB / 2 + 10 * CPB - 2) && act <= 32'(3 + CPB / 2 + 10 * CPB + 2)), 32'd1);
`else
            check("lat_cycles_ok", 32'(act >= 32'(3 + CPB / 2 + 9 * CPB - 2) && act <= 32'(3 + CPB / 2 + 9 * CPB + 2)), 32'd1);
`endif
        end

        // Vector table of single frames separated by idle gaps
        for (int i = 0; i < 7; i++) begin
            v0 = n_valid; f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            idle(2 * CPB);
            wait_idle($sformatf("v%0d_idle", i));
            if (vecs[i].exp_valid != 0) begin
                exp_data = vecs[i].data;
                exp_count++;
            end
            check($sformatf("v%0d_valid", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_ferr", i),  32'(n_ferr - f0),  32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_data", i),  32'(bus.rx_data),  32'(exp_data));
            check($sformatf("v%0d_count", i), 32'(bus.rx_count), 32'(exp_count));
        end

        // Back-to-back stream with no idle gap
        got_q.delete();
        v0 = n_valid;
        send_frame(8'h55, 1'b1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(2 * CPB);
        exp_data = 8'hFF; exp_count += 16'd3;
        check("stream_n", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            act = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
            check($sformatf("stream_b%0d", i), act, (i == 0) ? 32'h55 : (i == 1) ? 32'h00 : 32'hFF);
        end
        check("stream_count", 32'(bus.rx_count), 32'(exp_count));

        // Start-bit glitch of 5 cycles
        v0 = n_valid; f0 = n_ferr;
        bus.ser_rx = 1'b0;
        seen_busy = 1'b0;
        repeat (5) begin
            @(negedge clock);
            seen_busy |= bus.rx_busy;
        end
        bus.ser_rx = 1'b1;
        k = 0;
        while ((bus.rx_busy || !seen_busy) && k < 10) begin
            @(negedge clock);
            seen_busy |= bus.rx_busy;
            k++;
        end
        check("glitch_seen_busy", 32'(seen_busy), 32'd1);
        check("glitch_busy_clear", 32'(bus.rx_busy), 32'd0);
        idle(12 * CPB);
        check("glitch_strobes", 32'(n_valid - v0 + n_ferr - f0), 32'd0);

        // Framing error followed by a held-low break
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        bus.ser_rx = 1'b0;
        repeat (40 * CPB) @(negedge clock);
        check("break_busy", 32'(bus.rx_busy), 32'd1);
        check("break_ferr", 32'(n_ferr - f0), 32'd1);
        check("break_valid", 32'(n_valid - v0), 32'd0);
        check("break_data", 32'(bus.rx_data), 32'(exp_data));
        idle(4 * CPB);
        wait_idle("break_release_idle");
        send_frame(8'h41, 1'b1);
        idle(2 * CPB);
        exp_data = 8'h41; exp_count++;
        check("post_break_valid", 32'(n_valid - v0), 32'd1);
        check("post_break_data", 32'(bus.rx_data), 32'h41);
        check("post_break_ferr", 32'(n_ferr - f0), 32'd1);

        // Counter wrap: preload to 0xFFFF, one more byte wraps to 0
        force dut.rx_count_d = 16'hFFFF;
        @(negedge clock);
        release dut.rx_count_d;
        exp_count = 16'hFFFF;
        idle(2);
        check("wrap_preload", 32'(bus.rx_count), 32'hFFFF);
        v0 = n_valid;
        send_frame(8'h5A, 1'b1);
        idle(2 * CPB);
        exp_count++;
        check("wrap_valid", 32'(n_valid - v0), 32'd1);
        check("wrap_count", 32'(bus.rx_count), 32'(exp_count));

`ifdef TB_UART_PARITY_EN
        // 0x01 needs parity 1 for even parity; send 0
        v0 = n_valid; p0 = n_perr; f0 = n_ferr;
        send_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) send_bit(i == 0 ? 1'b1 : 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(2 * CPB);
        check("par_err", 32'(n_perr - p0), 32'd1);
        check("par_valid", 32'(n_valid - v0), 32'd0);
        check("par_data", 32'(bus.rx_data), 32'(exp_data));
        check("par_count", 32'(bus.rx_count), 32'(exp_count));
        check("par_ferr", 32'(n_ferr - f0), 32'd0);
`else
        p0 = n_perr;
        check("no_parity_strobes", 32'(n_perr - p0), 32'd0);
`endif

        check("strobe_overlap", 32'(n_both), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tb_uart.md
Name: tb_uart

Overview:
- Synthesizable 8N1 UART receiver/monitor that watches the SoC serial transmit pin (mprj_io[6]) in chip-level benches.
- Decodes bytes sent by firmware and presents each as a one-cycle strobe with data.
- Detects framing errors, rejects start-bit glitches, counts received bytes.
- Sits outside the chip model on the serial line; a single clock domain, the same clock as the chip.

Parameters:
- CLKS_PER_BIT, 1042, clock cycles per bit period (40 MHz / 38400 baud); legal range 4..65535.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- resetb  input  1  synchronous active-low reset.
- ser_rx  input  1  serial line, idle high, asynchronous to clock.
- rx_data  output  8  last correctly framed byte, LSB received first.
- rx_valid  output  1  one-cycle strobe, rx_data updated this cycle.
- frame_err  output  1  one-cycle strobe, stop bit sampled low.
- rx_busy  output  1  high whenever FSM is not IDLE.
- rx_count  output  16  number of valid bytes received, wraps 0xFFFF->0x0000.

Behaviour:
- Reset (resetb low at a clock edge): FSM=IDLE, rx_data=0x00, rx_valid=0, frame_err=0, rx_busy=0, rx_count=0; both synchronizer flops=1. Applies mid-frame; the partial byte is discarded with no strobe.
- ser_rx passes through a 2-flop synchronizer (rxs); all decisions use rxs. This adds 2 cycles of latency.
- Bit counter cnt and bit index idx are internal.
- IDLE: rxs==0 -> START, cnt=0.
- START: when cnt reaches CLKS_PER_BIT/2-1 (integer division), sample rxs.
  - rxs==0 -> DATA, cnt=0, idx=0.
  - rxs==1 -> glitch; return to IDLE with no strobe.
- DATA: when cnt reaches CLKS_PER_BIT-1, shift rxs into bit idx of the shift register (LSB first), cnt=0, idx++. After idx 7 is sampled -> STOP.
- STOP: when cnt reaches CLKS_PER_BIT-1, sample rxs.
  - rxs==1 -> next cycle: rx_valid=1, rx_data=shift register, rx_count+=1; FSM -> IDLE.
  - rxs==0 -> next cycle: frame_err=1, rx_data unchanged, rx_count unchanged; FSM -> BREAK.
- BREAK: wait until rxs==1, then IDLE. A held-low line produces exactly one frame_err and no further frames.
- Strobes are exactly one cycle wide. rx_valid and frame_err are never high together.
- Back-to-back frames: a start bit immediately following the stop-bit sample is accepted, because IDLE is re-entered within 1 cycle of the stop-bit sample.
- Latency: rx_valid rises about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the falling start edge on ser_rx (±1).
- cnt width is 16 bits. No output is combinationally dependent on ser_rx.

Optional Feature:
- Macro TB_UART_PARITY_EN.
- When defined:
  - Frame is 8E1: an even-parity bit follows data bit 7 and is sampled in a PARITY state, one bit period after bit 7, before STOP.
  - Adds output parity_err (1 bit). It pulses one cycle instead of rx_valid when the stop bit is good but parity mismatches; rx_data and rx_count are unchanged in that case.
  - A bad stop bit takes precedence: frame_err only.
- When undefined: no PARITY state and no parity_err port. Frame is 8N1 exactly as above.

Test Plan:
- Reset: hold resetb=0 for 3 cycles with ser_rx toggling -> all outputs 0, rx_busy=0. Then assert resetb low mid-frame -> no strobe, rx_count unchanged from 0.
- Single byte, CLKS_PER_BIT=16: send 0xA5 8N1 -> one rx_valid pulse, rx_data=0xA5, rx_count=1, frame_err never high.
- Stream: send 0x55,0x00,0xFF back-to-back with no idle gap -> three rx_valid pulses in order, rx_count=3.
- Glitch: ser_rx low for 5 cycles (CLKS_PER_BIT=16) -> no strobe, rx_busy returns 0 within 10 cycles.
- Framing/break: send 0x3C with stop bit low and line held low 40 bit times -> exactly one frame_err pulse, rx_data keeps previous value. Then release and send 0x41 -> rx_valid, rx_data=0x41.
- Wrap and parity: preload by sending 65536 bytes -> rx_count=0x0000. With TB_UART_PARITY_EN, 0x01 with parity bit 0 -> parity_err pulse, no rx_valid.
